key_cond: RTL and testbench
===========================

Name: key_cond

Overview:
Input conditioning stage that sits directly upstream of the wash controller. It takes raw, bouncing push-button and switch inputs from the board. It produces clean debounced levels and single-cycle press and release pulses, with auto-repeat on long holds. The controller's digit-increment and position-advance inputs are driven from key_press, so one physical press advances a digit exactly once, and holding the button scrolls it.

Parameters:
N_KEYS, 4, number of independent key channels
DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz)
HOLD_CYCLES, 50000000, cycles from the initial press pulse to the first auto-repeat pulse (0.5 s)
REP_CYCLES, 20000000, cycles between subsequent auto-repeat pulses (0.2 s)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
key_raw  input  N_KEYS  raw buttons, active-high, asynchronous to clk, bouncing
en  input  1  pulse enable; level tracking continues when low
key_level  output  N_KEYS  debounced level per key
key_press  output  N_KEYS  1-cycle pulse on an accepted press and on each auto-repeat
key_rel  output  N_KEYS  1-cycle pulse on an accepted release

Behaviour:
- Reset (rst low, async): synchronizer flops, key_level, key_press and key_rel all go to 0. All counters clear to 0. All channel FSMs go to IDLE.
- Reset mid-hold: the channel returns to IDLE and produces no pulses. After reset release, a key still held is accepted as a new press after the normal debounce latency.
- Synchronizer: each key_raw bit passes through a 2-flop synchronizer (s1 -> s2). Only s2 is used downstream.
- Debounce, per key:
  - Counter dcnt, width clog2(DEB_CYCLES+1).
  - If s2 == key_level, dcnt clears to 0.
  - Otherwise dcnt increments. When dcnt reaches DEB_CYCLES-1 while s2 still differs, key_level toggles on that edge and dcnt clears.
  - Any single sample equal to key_level restarts the count, so a glitch shorter than DEB_CYCLES never changes key_level.
- Latency: a clean raw 0->1 step sampled at edge k gives key_level = 1 after edge k+1+DEB_CYCLES. key_press is high in the same cycle that key_level first reads 1.
- Channel FSM, per key, with hold/repeat counter hcnt of width clog2(max(HOLD,REP)+1):
  - IDLE: on the key_level rise, pulse key_press and go to HOLD with hcnt = 0.
  - HOLD: hcnt increments every cycle. When hcnt == HOLD_CYCLES-1, pulse key_press, clear hcnt, and go to REPEAT.
  - REPEAT: hcnt increments. When hcnt == REP_CYCLES-1, pulse key_press and clear hcnt.
  - HOLD or REPEAT: on the key_level fall, pulse key_rel, go to IDLE, and clear hcnt. No key_press is issued in that cycle, even if hcnt was at terminal count.
- en handling:
  - When en = 0, key_press and key_rel are forced to 0.
  - key_level, debounce and the FSM keep running. Events that occur while en = 0 are lost, not queued.
  - A press pulse is output only if en = 1 in the cycle it is generated.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses in the same cycle.
- All outputs are registered. key_press and key_rel are never high for two consecutive cycles on the same bit, except where REP_CYCLES = 1 (not a supported configuration; minimum is 2).
- Counter wrap: dcnt and hcnt never wrap; they saturate at their terminal counts by construction.

Test Plan:
Parameters for all scenarios: DEB_CYCLES=4, HOLD_CYCLES=10, REP_CYCLES=5; en=1 unless stated.
1. Reset then clean press of key 0 at edge 0, held 8 cycles:
   - key_level[0] rises at edge 5.
   - key_press[0] is high exactly one cycle at edge 5.
   - On release, key_rel[0] pulses once, 6 edges after the raw fall.
2. Bounce:
   - key_raw[1] toggles 1,0,1,0 each cycle, then stays 1.
   - No pulse during the bounce. key_level[1] rises 6 edges after the last toggle, with one key_press[1].
3. Long hold of key 2 for 40 cycles after acceptance:
   - key_press[2] pulses at acceptance cycle A, then at A+10, A+15, A+20, … while held.
   - Exactly one key_rel[2] on release.
4. Release on terminal count:
   - Release key 2 so key_level falls in the cycle hcnt hits HOLD_CYCLES-1.
   - Only key_rel[2] pulses; no key_press[2].
5. Simultaneous keys and en:
   - Press keys 0 and 3 together with en = 1: both key_press bits pulse in the same cycle.
   - Repeat the press with en = 0: key_level follows, but both pulse outputs stay 0.
6. Async reset mid-hold:
   - Assert rst while key 1 is in REPEAT: all outputs go to 0 immediately.
   - Deassert with key 1 still held: one new key_press[1] pulse DEB_CYCLES+2 edges later.

Source files
------------

// File: rtl/key_cond.sv
// Key conditioning: 2-flop sync, per-key debounce, press/release pulses with auto-repeat.
// state  | meaning
// IDLE   | debounced level low, waiting for an accepted press
// HOLD   | pressed, counting towards the first auto-repeat
// REPEAT | held past the hold delay, pulsing every REP_CYCLES
module key_cond #(
  parameter int N_KEYS      = 4,
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REP_CYCLES  = 20000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_rel
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_TC  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_TC  = HW'(REP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    state_t        state;
    logic          lvl;
    logic          prs;
    logic          rel;
    logic          lvl_nxt;
    logic          rise;
    logic          fall;

    // Edge detection looks at the level being written this cycle, so the
    // press pulse lines up with the first cycle key_level reads high.
    always_comb begin
      lvl_nxt = lvl;
      if ((s2[g] != lvl) && (dcnt == DEB_TC)) lvl_nxt = ~lvl;
    end

    assign rise = lvl_nxt & ~lvl;
    assign fall = ~lvl_nxt & lvl;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dcnt <= '0;
        lvl  <= 1'b0;
      end else if (s2[g] == lvl) begin
        dcnt <= '0;
      end else if (dcnt == DEB_TC) begin
        dcnt <= '0;
        lvl  <= ~lvl;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        hcnt  <= '0;
        prs   <= 1'b0;
        rel   <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        case (state)
          IDLE: begin
            if (rise) begin
              prs   <= en;
              hcnt  <= '0;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (fall) begin
              rel   <= en;
              hcnt  <= '0;
              state <= IDLE;
            end else if (hcnt == HOLD_TC) begin
              prs   <= en;
              hcnt  <= '0;
              state <= REPEAT;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (fall) begin
              rel   <= en;
              hcnt  <= '0;
              state <= IDLE;
            end else if (hcnt == REP_TC) begin
              prs  <= en;
              hcnt <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          default: begin
            hcnt  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end

    assign key_level[g] = lvl;
    assign key_press[g] = prs;
    assign key_rel[g]   = rel;
  end

endmodule

// File: tb/tb_key_cond.sv
// Bench for key_cond: vector table, hand-written corner sequences and random
// stimulus, all compared every cycle against a timing-based reference model.
module tb_key_cond;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         en      = 1'b0;
  logic [N-1:0] key_raw = '0;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_rel;

  key_cond #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .en(en),
    .key_level(key_level), .key_press(key_press), .key_rel(key_rel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: sync pipeline, run length of disagreeing samples, and
  // the time of the last accepted press from which repeat times are derived.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int m_run[N];
  int m_rise[N];

  int cnt_press[N];
  int cnt_rel[N];
  int cnt_lvl[N];
  int first_press[N];

  typedef struct {
    logic [N-1:0] mask;
    logic         en_v;
    int           hold;
    int           exp_press;
    int           exp_rel;
    int           exp_lvl;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_rise[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] sample;
    logic [N-1:0] old;
    int el;
    if (!rst) begin
      model_reset();
      return;
    end
    sample  = m_s2;
    m_s2    = m_s1;
    m_s1    = key_raw;
    old     = m_lvl;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (sample[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_lvl[i] && !old[i]) m_rise[i] = cyc;
      if (!m_lvl[i] && old[i]) begin
        m_rel[i] = en;
      end else if (m_lvl[i]) begin
        el = cyc - m_rise[i];
        if (el == 0 || el == HOLD || (el > HOLD && (el - HOLD) % REP == 0))
          m_press[i] = en;
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      cnt_press[i]   = 0;
      cnt_rel[i]     = 0;
      cnt_lvl[i]     = 0;
      first_press[i] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("outputs_vs_model", {20'd0, key_level, key_press, key_rel}, {20'd0, m_lvl, m_press, m_rel});
    for (int i = 0; i < N; i++) begin
      if (key_press[i]) begin
        cnt_press[i]++;
        if (first_press[i] < 0) first_press[i] = cyc;
      end
      if (key_rel[i])   cnt_rel[i]++;
      if (key_level[i]) cnt_lvl[i]++;
    end
  endtask

  initial begin
    int start;
    int base;
    vec_t v;

    // mask, en, raw-high cycles, presses, releases, level-high cycles
    vecs[0] = '{4'b0001, 1'b1,  8, 1, 1,  8};
    vecs[1] = '{4'b0100, 1'b1, 40, 7, 1, 40};
    vecs[2] = '{4'b0100, 1'b1, 10, 1, 1, 10};
    vecs[3] = '{4'b0100, 1'b1, 11, 2, 1, 11};
    vecs[4] = '{4'b1001, 1'b1,  8, 1, 1,  8};
    vecs[5] = '{4'b1001, 1'b0,  8, 0, 0,  8};
    vecs[6] = '{4'b0010, 1'b1, 21, 4, 1, 21};
    vecs[7] = '{4'b0010, 1'b1,  3, 0, 0,  0};

    model_reset();
    clear_counts();
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) tick();
    check("reset_state", {20'd0, key_level, key_press, key_rel}, 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      clear_counts();
      en      = v.en_v;
      key_raw = v.mask;
      start   = cyc + 1;
      repeat (v.hold) tick();
      key_raw = '0;
      repeat (DEB + 4) tick();
      for (int i = 0; i < N; i++) begin
        if (v.mask[i]) begin
          check($sformatf("vec%0d_key%0d_press_count", k, i), cnt_press[i], v.exp_press);
          check($sformatf("vec%0d_key%0d_rel_count", k, i), cnt_rel[i], v.exp_rel);
          check($sformatf("vec%0d_key%0d_level_cycles", k, i), cnt_lvl[i], v.exp_lvl);
          if (v.exp_press > 0)
            check($sformatf("vec%0d_key%0d_press_latency", k, i), first_press[i] - start, DEB + 1);
        end else begin
          check($sformatf("vec%0d_key%0d_idle", k, i), cnt_press[i] + cnt_rel[i] + cnt_lvl[i], 0);
        end
      end
    end
    en = 1'b1;

    // Bounce on key 1: 1,0,1,0 then steady 1.
    clear_counts();
    key_raw[1] = 1'b1; tick();
    key_raw[1] = 1'b0; tick();
    key_raw[1] = 1'b1; tick();
    key_raw[1] = 1'b0; tick();
    key_raw[1] = 1'b1; tick();
    base = cyc;
    repeat (DEB) tick();
    check("bounce_no_early_pulse", cnt_press[1] + cnt_rel[1], 0);
    check("bounce_level_still_low", key_level[1], 1'b0);
    tick();
    check("bounce_level_rise", key_level[1], 1'b1);
    check("bounce_press_edge", first_press[1] - base, DEB + 1);
    check("bounce_press_count", cnt_press[1], 1);
    key_raw = '0;
    repeat (DEB + 4) tick();
    check("bounce_rel_count", cnt_rel[1], 1);

    // Async reset while key 1 is auto-repeating.
    clear_counts();
    key_raw[1] = 1'b1;
    repeat (DEB + 1 + HOLD + 2 * REP + 2) tick();
    check("pre_reset_repeating", cnt_press[1], 4);
    rst = 1'b0;
    #1;
    check("async_reset_immediate", {20'd0, key_level, key_press, key_rel}, 32'd0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    clear_counts();
    base = cyc;
    repeat (DEB + 2) tick();
    check("post_reset_press_edge", first_press[1] - base, DEB + 2);
    check("post_reset_press_count", cnt_press[1], 1);
    key_raw = '0;
    repeat (DEB + 4) tick();
    check("post_reset_rel_count", cnt_rel[1], 1);

    // Random bouncing on all keys with occasional en drops.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) key_raw[i] = ~key_raw[i];
      en = ($urandom_range(0, 7) != 0);
      tick();
    end
    key_raw = '0;
    en      = 1'b1;
    repeat (DEB + 4) tick();
    check("final_idle", {28'd0, key_level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
